// File: rtl/led_sequencer.sv
// led_sequencer: owns the 8-LED bank, plays the boot fill, then arbitrates it between two clients
// Ports:
//   clock            rising-edge clock, single domain
//   reset_n          asynchronous active-low reset
//   req[1:0]         level-sensitive request from client 0/1
//   pattern0/1[7:0]  LED pattern offered by client 0/1
//   fault            synchronous fault level (acted on only with LED_SEQ_FAULT_BLINK_EN)
//   grant[1:0]       one-hot owner of the LEDs, or zero
//   busy             high while the boot animation runs
//   leds[7:0]        registered LED drive
// Build option: define LED_SEQ_FAULT_BLINK_EN to add the full-bank fault blink state.
module led_sequencer #(
  parameter int TICK_CYCLES    = 100_000,
  parameter int MIN_HOLD_TICKS = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [7:0] pattern0,
  input  logic [7:0] pattern1,
  input  logic       fault,
  output logic [1:0] grant,
  output logic       busy,
  output logic [7:0] leds
);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam int HW = $clog2(MIN_HOLD_TICKS + 1);
  localparam logic [TW-1:0] TMAX = TW'(TICK_CYCLES - 1);
  localparam logic [HW-1:0] HMAX = HW'(MIN_HOLD_TICKS);
  typedef enum logic [1:0] {
    s_boot,
    s_idle,
    s_own
`ifdef LED_SEQ_FAULT_BLINK_EN
    , s_fault
`endif
  } state_t;
  state_t state, state_d;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hold, hold_d;
  logic [7:0] leds_d;
  logic [1:0] grant_d;
  logic busy_d, last_owner, last_d, tick, owner, other, pick;
  assign tick  = tcnt == TMAX;
  assign owner = grant[1];
  assign other = ~owner;
  // With both requesting, the client that did not own last wins; a lone requester always wins.
  assign pick  = req[1] & (~req[0] | ~last_owner);
  // Free-running tick base, never disturbed by state changes so hold and blink stay phase-aligned.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + TW'(1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state      <= s_boot;
      leds       <= 8'h00;
      grant      <= 2'b00;
      busy       <= 1'b1;
      hold       <= '0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_d;
      leds       <= leds_d;
      grant      <= grant_d;
      busy       <= busy_d;
      hold       <= hold_d;
      last_owner <= last_d;
    end
  always_comb begin
    state_d = state;
    leds_d  = leds;
    grant_d = grant;
    busy_d  = busy;
    hold_d  = hold;
    last_d  = last_owner;
    case (state)
      s_boot: if (tick) begin
        leds_d  = leds == 8'hff ? 8'h00 : {leds[6:0], 1'b1};
        busy_d  = leds != 8'hff;
        state_d = leds == 8'hff ? s_idle : s_boot;
      end
      s_idle: if (|req) begin
        grant_d = pick ? 2'b10 : 2'b01;
        leds_d  = pick ? pattern1 : pattern0;
        hold_d  = '0;
        last_d  = pick;
        state_d = s_own;
      end
      s_own: begin
        leds_d = owner ? pattern1 : pattern0;
        hold_d = (tick && hold != HMAX) ? hold + HW'(1) : hold;
        // Hand off when the owner lets go, or when it has held long enough and the other waits.
        if (req[other] && (!req[owner] || hold == HMAX)) begin
          grant_d = owner ? 2'b01 : 2'b10;
          leds_d  = owner ? pattern0 : pattern1;
          hold_d  = '0;
          last_d  = other;
        end else if (!req[owner]) begin
          grant_d = 2'b00;
          leds_d  = 8'h00;
          state_d = s_idle;
        end
      end
`ifdef LED_SEQ_FAULT_BLINK_EN
      s_fault: begin
        leds_d  = fault ? (tick ? ~leds : leds) : 8'h00;
        state_d = fault ? s_fault : s_idle;
      end
`endif
      default: state_d = s_boot;
    endcase
`ifdef LED_SEQ_FAULT_BLINK_EN
    // Fault overrides boot and arbitration; boot is not resumed afterwards.
    if (fault && state != s_fault) begin
      state_d = s_fault;
      grant_d = 2'b00;
      busy_d  = 1'b0;
      leds_d  = 8'hff;
    end
`endif
  end
`ifndef LED_SEQ_FAULT_BLINK_EN
  logic unused_fault;
  assign unused_fault = fault;
`endif
endmodule

// File: tb/tb_led_sequencer.sv
// tb_led_sequencer: directed self-checking bench for led_sequencer (TICK_CYCLES=4, MIN_HOLD_TICKS=2)
module tb_led_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic [7:0] pattern0 = 8'ha5;
  logic [7:0] pattern1 = 8'h3c;
  logic fault = 1'b0;
  logic [1:0] grant;
  logic busy;
  logic [7:0] leds;
  int checks = 0;
  int errors = 0;
  int bad11 = 0;
  led_sequencer #(.TICK_CYCLES(4), .MIN_HOLD_TICKS(2)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .pattern0(pattern0), .pattern1(pattern1),
    .fault(fault), .grant(grant), .busy(busy), .leds(leds)
  );
  always #5 clock = ~clock;
  always @(negedge clock) if (reset_n && grant === 2'b11) bad11++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic out(input string tag, input logic [1:0] g, input logic [7:0] l);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_leds"}, 32'(leds), 32'(l));
  endtask
  initial begin
    #2 reset_n = 1'b0;
    #1;
    out("reset", 2'b00, 8'h00);
    chk("reset_busy", 32'(busy), 32'd1);
    req = 2'b01;
    @(negedge clock) reset_n = 1'b1;
    step(3);  out("e3", 2'b00, 8'h00);
    step(1);  out("e4", 2'b00, 8'h01);
    step(4);  out("e8", 2'b00, 8'h03);
    step(24); out("e32", 2'b00, 8'hff);
    chk("e32_busy", 32'(busy), 32'd1);
    step(3);  out("e35", 2'b00, 8'hff);
    step(1);  out("e36", 2'b00, 8'h00);
    chk("e36_busy", 32'(busy), 32'd0);
    step(1);  out("e37_grant0", 2'b01, 8'ha5);
    pattern0 = 8'h5a;
    step(1);  out("follow", 2'b01, 8'h5a);
    req = 2'b11;
    step(6);  out("hold0", 2'b01, 8'h5a);
    step(1);  out("preempt01", 2'b10, 8'h3c);
    step(7);  out("hold1", 2'b10, 8'h3c);
    step(1);  out("preempt10", 2'b01, 8'h5a);
    req = 2'b01;
    step(1);  out("keep0", 2'b01, 8'h5a);
    req = 2'b00;
    step(1);  out("release0", 2'b00, 8'h00);
    req = 2'b10;
    step(1);  out("lone1", 2'b10, 8'h3c);
    req = 2'b00;
    step(1);  out("release1", 2'b00, 8'h00);
    req = 2'b01;
    step(1);  out("lone0", 2'b01, 8'h5a);
    req = 2'b10;
    step(1);  out("drop_handoff", 2'b10, 8'h3c);
    req = 2'b00;
    step(1);  out("idle_a", 2'b00, 8'h00);
    req = 2'b11;
    step(1);  out("rr_to0", 2'b01, 8'h5a);
    req = 2'b00;
    step(1);  out("idle_b", 2'b00, 8'h00);
    req = 2'b11;
    step(1);  out("rr_to1", 2'b10, 8'h3c);
    req = 2'b00;
    step(1);  out("idle_c", 2'b00, 8'h00);
    req = 2'b01;
    step(1);  out("own_pre_fault", 2'b01, 8'h5a);
    fault = 1'b1;
`ifdef LED_SEQ_FAULT_BLINK_EN
    step(1);  out("fault_entry", 2'b00, 8'hff);
    chk("fault_busy", 32'(busy), 32'd0);
    step(1);  out("fault_e67", 2'b00, 8'hff);
    step(1);  out("fault_e68", 2'b00, 8'h00);
    step(3);  out("fault_e71", 2'b00, 8'h00);
    step(1);  out("fault_e72", 2'b00, 8'hff);
    fault = 1'b0;
    step(1);  out("fault_exit", 2'b00, 8'h00);
    step(1);  out("rearb", 2'b01, 8'h5a);
`else
    step(1);  out("fault_ignored_a", 2'b01, 8'h5a);
    step(2);  out("fault_ignored_b", 2'b01, 8'h5a);
    chk("fault_ignored_busy", 32'(busy), 32'd0);
    fault = 1'b0;
`endif
    reset_n = 1'b0;
    #1;
    out("midreset", 2'b00, 8'h00);
    chk("midreset_busy", 32'(busy), 32'd1);
    req = 2'b11;
    @(negedge clock) reset_n = 1'b1;
    step(4);  out("reboot_e4", 2'b00, 8'h01);
    chk("reboot_busy", 32'(busy), 32'd1);
    step(31); out("reboot_e35", 2'b00, 8'hff);
    step(1);  out("reboot_e36", 2'b00, 8'h00);
    chk("reboot_done_busy", 32'(busy), 32'd0);
    step(1);  out("first_contest", 2'b01, 8'h5a);
    chk("never_both_granted", 32'(bad11), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
